// File: rtl/id_ex_reg_pkg.sv
// Shared constants for the ID/EX pipeline register: bus widths, NOP
// encodings and the control-field encodings the hazard check needs.
package id_ex_reg_pkg;

    localparam int unsigned DATA_BUS_W     = 16;
    localparam int unsigned REG_ADDR_BUS_W = 4;
    localparam int unsigned ALU_OP_W       = 4;
    localparam int unsigned MUX_OP_W       = 3;
    localparam int unsigned REG_OP_W       = 3;
    localparam int unsigned WB_DATA_OP_W   = 3;
    localparam int unsigned MEM_OP_W       = 2;

    localparam logic [DATA_BUS_W-1:0] EMPTY_DATA = '0;

    localparam logic [ALU_OP_W-1:0] ALU_OP_NOP = 4'h0;
    localparam logic [MUX_OP_W-1:0] MUX_OP_NONE = 3'd0;

    // Destination register class
    localparam logic [REG_OP_W-1:0] REG_OP_NOP = 3'd0;
    localparam logic [REG_OP_W-1:0] REG_OP_GPR = 3'd1;
    localparam logic [REG_OP_W-1:0] REG_OP_IH  = 3'd2;
    localparam logic [REG_OP_W-1:0] REG_OP_SP  = 3'd3;
    localparam logic [REG_OP_W-1:0] REG_OP_T   = 3'd4;

    // Writeback data source
    localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_NOP = 3'd0;
    localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_ALU = 3'd1;
    localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_MEM = 3'd2;
    localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_PC  = 3'd3;

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [MEM_OP_W-1:0] MEM_OP_READ  = 2'd1;
    localparam logic [MEM_OP_W-1:0] MEM_OP_WRITE = 2'd2;

endpackage

// File: rtl/id_ex_reg_load_use_detect.sv
// Load-use hazard compare: the instruction in EX is a load that writes a
// register the ID instruction actually reads.
module load_use_detect
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_BUS_W
) (
    input  logic                    ex_valid,
    input  logic [WB_DATA_OP_W-1:0] ex_wb_data_op,
    input  logic [REG_OP_W-1:0]     ex_reg_op,
    input  logic [ADDR_W-1:0]       ex_wb_addr,
    input  logic                    id_valid,
    input  logic                    id_reg1_used,
    input  logic [ADDR_W-1:0]       id_reg1_addr,
    input  logic                    id_reg2_used,
    input  logic [ADDR_W-1:0]       id_reg2_addr,
    output logic                    hazard
);

    logic ex_is_load;
    logic src_match;

    // Compare ID source operands against the pending load destination
    always_comb begin
        ex_is_load = ex_valid && (ex_wb_data_op == WB_DATA_OP_MEM) && (ex_reg_op != REG_OP_NOP);
        src_match  = (id_reg1_used && (id_reg1_addr == ex_wb_addr)) ||
                     (id_reg2_used && (id_reg2_addr == ex_wb_addr));
        hazard     = ex_is_load && id_valid && src_match;
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with forwarded-operand capture, load-use bubble
// insertion and a saturating count of inserted load-use bubbles.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_BUS_W,
    parameter int unsigned ADDR_W = REG_ADDR_BUS_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    flush_i,
    input  logic                    id_valid,
    input  logic [DATA_W-1:0]       id_pc,
    input  logic [DATA_W-1:0]       id_imm,
    input  logic [DATA_W-1:0]       id_reg1_data,
    input  logic [DATA_W-1:0]       id_reg2_data,
    input  logic [ADDR_W-1:0]       id_reg1_addr,
    input  logic [ADDR_W-1:0]       id_reg2_addr,
    input  logic [ADDR_W-1:0]       id_wb_addr,
    input  logic                    id_reg1_used,
    input  logic                    id_reg2_used,
    input  logic [ALU_OP_W-1:0]     id_alu_op,
    input  logic [MUX_OP_W-1:0]     id_op1_mux_op,
    input  logic [MUX_OP_W-1:0]     id_op2_mux_op,
    input  logic [REG_OP_W-1:0]     id_reg_op,
    input  logic [WB_DATA_OP_W-1:0] id_wb_data_op,
    input  logic [MEM_OP_W-1:0]     id_mem_op,
    input  logic [DATA_W-1:0]       reg1_forward_data,
    input  logic [DATA_W-1:0]       reg2_forward_data,
    input  logic                    reg1_forward_enable,
    input  logic                    reg2_forward_enable,
    output logic                    ex_valid,
    output logic [DATA_W-1:0]       ex_pc,
    output logic [DATA_W-1:0]       ex_imm,
    output logic [DATA_W-1:0]       ex_reg1_data,
    output logic [DATA_W-1:0]       ex_reg2_data,
    output logic [ADDR_W-1:0]       ex_reg1_addr,
    output logic [ADDR_W-1:0]       ex_reg2_addr,
    output logic [ADDR_W-1:0]       ex_wb_addr,
    output logic [ALU_OP_W-1:0]     ex_alu_op,
    output logic [MUX_OP_W-1:0]     ex_op1_mux_op,
    output logic [MUX_OP_W-1:0]     ex_op2_mux_op,
    output logic [REG_OP_W-1:0]     ex_reg_op,
    output logic [WB_DATA_OP_W-1:0] ex_wb_data_op,
    output logic [MEM_OP_W-1:0]     ex_mem_op,
    output logic                    load_use_stall,
    output logic [CNT_W-1:0]        bubble_cnt
);

    logic              hazard;
    logic [DATA_W-1:0] op1_sel;
    logic [DATA_W-1:0] op2_sel;

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_load_use_detect (
        .ex_valid      (ex_valid),
        .ex_wb_data_op (ex_wb_data_op),
        .ex_reg_op     (ex_reg_op),
        .ex_wb_addr    (ex_wb_addr),
        .id_valid      (id_valid),
        .id_reg1_used  (id_reg1_used),
        .id_reg1_addr  (id_reg1_addr),
        .id_reg2_used  (id_reg2_used),
        .id_reg2_addr  (id_reg2_addr),
        .hazard        (hazard)
    );

    // Operand select and front-end stall request; flush/stall own the edge
    always_comb begin
        op1_sel        = reg1_forward_enable ? reg1_forward_data : id_reg1_data;
        op2_sel        = reg2_forward_enable ? reg2_forward_data : id_reg2_data;
        load_use_stall = hazard && !stall_i && !flush_i;
    end

    // Pipeline register: flush > stall > load-use bubble > capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush_i || (!stall_i && hazard)) begin
            if (!rst || flush_i || hazard) begin
                ex_valid      <= 1'b0;
                ex_pc         <= DATA_W'(EMPTY_DATA);
                ex_imm        <= DATA_W'(EMPTY_DATA);
                ex_reg1_data  <= DATA_W'(EMPTY_DATA);
                ex_reg2_data  <= DATA_W'(EMPTY_DATA);
                ex_reg1_addr  <= '0;
                ex_reg2_addr  <= '0;
                ex_wb_addr    <= '0;
                ex_alu_op     <= ALU_OP_NOP;
                ex_op1_mux_op <= MUX_OP_NONE;
                ex_op2_mux_op <= MUX_OP_NONE;
                ex_reg_op     <= REG_OP_NOP;
                ex_wb_data_op <= WB_DATA_OP_NOP;
                ex_mem_op     <= MEM_OP_NOP;
            end
        end else if (!stall_i) begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            ex_imm        <= id_imm;
            ex_reg1_data  <= op1_sel;
            ex_reg2_data  <= op2_sel;
            ex_reg1_addr  <= id_reg1_addr;
            ex_reg2_addr  <= id_reg2_addr;
            ex_wb_addr    <= id_wb_addr;
            ex_alu_op     <= id_alu_op;
            ex_op1_mux_op <= id_op1_mux_op;
            ex_op2_mux_op <= id_op2_mux_op;
            ex_reg_op     <= id_reg_op;
            ex_wb_data_op <= id_wb_data_op;
            ex_mem_op     <= id_mem_op;
        end
    end

    // Count only load-use bubbles, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (load_use_stall && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule
